// File: rtl/cba_row_readout_ctrl_pkg.sv
// Shared constants and state encoding for the core-column row readout controller.
package cba_row_readout_ctrl_pkg;

    localparam int NROWS  = 16;
    localparam int ADDR_W = 4;
    localparam int NPIX   = 4;
    localparam int TOT_W  = 4;
    localparam int CNT_W  = 5;

    function automatic int ROW_TOT_W();
        return NPIX * TOT_W;
    endfunction

    localparam int ROW_W  = ROW_TOT_W();
    localparam int DATA_W = ADDR_W + ROW_W;

    typedef enum logic [1:0] {IDLE, SELECT, SEND, DONE} state_t;

endpackage

// File: rtl/cba_row_readout_ctrl_if.sv
// Request, hit/ToT, output-word handshake and status signals of the row readout controller.
interface cba_row_readout_ctrl_if;
    import cba_row_readout_ctrl_pkg::*;

    logic                     ReadReq;
    logic [NROWS-1:0]         HitIn;
    logic [NROWS*ROW_W-1:0]   TotIn;
    logic [DATA_W-1:0]        DataOut;
    logic                     DataValid;
    logic                     DataReady;
    logic [NROWS-1:0]         ClearRow;
    logic                     Busy;
    logic                     Done;
    logic [CNT_W-1:0]         WordCnt;

    // master: the pixel matrix plus downstream sink; slave: the controller
    modport master (
        output ReadReq, HitIn, TotIn, DataReady,
        input  DataOut, DataValid, ClearRow, Busy, Done, WordCnt
    );
    modport slave (
        input  ReadReq, HitIn, TotIn, DataReady,
        output DataOut, DataValid, ClearRow, Busy, Done, WordCnt
    );

endinterface

// File: rtl/cba_row_readout_ctrl_row_priority_enc.sv
// Lowest-set-bit encoder: the lowest pending row holds the readout token.
module cba_row_readout_ctrl_row_priority_enc
    import cba_row_readout_ctrl_pkg::*;
(
    input  logic [NROWS-1:0]  pending,
    output logic [ADDR_W-1:0] addr,
    output logic              any
);

    always_comb begin
        addr = '0;
        any  = |pending;
        // descending scan so the lowest set bit wins
        for (int i = NROWS - 1; i >= 0; i--) begin
            if (pending[i]) addr = ADDR_W'(i);
        end
    end

endmodule

// File: rtl/cba_row_readout_ctrl.sv
// Row readout FSM: snapshots hit rows, emits {addr,ToT} per pending row in ascending order, clears each row on accept.
module cba_row_readout_ctrl
    import cba_row_readout_ctrl_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    cba_row_readout_ctrl_if.slave        bus
);

    state_t             state;
    logic [NROWS-1:0]   pending;
    logic [ADDR_W-1:0]  addr;
    logic [ROW_W-1:0]   data;
    logic [CNT_W-1:0]   cnt;
    logic               data_valid;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   word_cnt;

    logic [ADDR_W-1:0]  sel_addr;
    logic               sel_any;
    logic [NROWS-1:0]   addr_onehot;
    logic [NROWS-1:0]   pending_nxt;
    logic               handshake;

    cba_row_readout_ctrl_row_priority_enc u_enc (
        .pending (pending),
        .addr    (sel_addr),
        .any     (sel_any)
    );

    // a handshake coinciding with reset is discarded, so no clear may escape
    assign handshake   = data_valid && bus.DataReady && !rst;
    assign addr_onehot = NROWS'(1) << addr;
    assign pending_nxt = pending & ~addr_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            addr       <= '0;
            data       <= '0;
            cnt        <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_cnt   <= '0;
        end else begin
            done     <= 1'b0;
            word_cnt <= '0;
            case (state)
                IDLE: begin
                    if (bus.ReadReq) begin
                        pending <= bus.HitIn;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= SELECT;
                    end
                end
                SELECT: begin
                    if (!sel_any) begin
                        done     <= 1'b1;
                        word_cnt <= cnt;
                        state    <= DONE;
                    end else begin
                        addr       <= sel_addr;
                        data       <= bus.TotIn[sel_addr*ROW_W +: ROW_W];
                        data_valid <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (bus.DataReady) begin
                        pending    <= pending_nxt;
                        cnt        <= cnt + CNT_W'(1);
                        data_valid <= 1'b0;
                        if (|pending_nxt) begin
                            state <= SELECT;
                        end else begin
                            done     <= 1'b1;
                            word_cnt <= cnt + CNT_W'(1);
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ClearRow = '0;
        if (handshake) bus.ClearRow = addr_onehot;
    end

    assign bus.DataOut   = {addr, data};
    assign bus.DataValid = data_valid;
    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.WordCnt   = word_cnt;

endmodule

// File: tb/tb_cba_row_readout_ctrl.sv
// Directed bench for the row readout controller with a word/count scoreboard.
module tb_cba_row_readout_ctrl;
    import cba_row_readout_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    cba_row_readout_ctrl_if bus();

    cba_row_readout_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int req_cyc = 0;
    int done_cyc = 0;
    int last_hs = 0;
    int words = 0;
    bit valid_seen = 0;
    bit done_seen = 0;
    bit tput_chk = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [CNT_W-1:0]  cnt_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [DATA_W-1:0] w;
        logic [ADDR_W-1:0] wa;
        if (rst) begin
            check("clear_in_reset", 64'(bus.ClearRow), 64'd0);
        end else begin
            if (bus.DataValid && !valid_seen) begin
                valid_seen = 1;
                check("first_valid_latency", 64'(cyc - req_cyc), 64'd2);
            end
            if (bus.DataValid && bus.DataReady) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(bus.DataValid), 64'd0);
                end else begin
                    w  = exp_q.pop_front();
                    wa = w[ROW_W +: ADDR_W];
                    check("word", 64'(bus.DataOut), 64'(w));
                    check("clear_onehot", 64'(bus.ClearRow), 64'(NROWS'(1) << wa));
                end
                if (tput_chk && words > 0) check("throughput", 64'(cyc - last_hs), 64'd2);
                last_hs = cyc;
                words++;
            end else begin
                check("clear_quiet", 64'(bus.ClearRow), 64'd0);
            end
            if (bus.Done) begin
                if (cnt_q.size() == 0) check("unexpected_done", 64'(bus.Done), 64'd0);
                else check("word_cnt", 64'(bus.WordCnt), 64'(cnt_q.pop_front()));
                done_seen = 1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic start_frame(input logic [NROWS-1:0] hit);
        @(posedge clk); #1;
        bus.HitIn = hit;
        for (int i = 0; i < NROWS*ROW_W/32; i++) bus.TotIn[i*32 +: 32] = $urandom();
        for (int k = 0; k < NROWS; k++)
            if (hit[k]) exp_q.push_back({ADDR_W'(k), bus.TotIn[k*ROW_W +: ROW_W]});
        cnt_q.push_back(CNT_W'($countones(hit)));
        valid_seen = 0;
        done_seen  = 0;
        words      = 0;
        req_cyc    = cyc;
        bus.ReadReq = 1'b1;
        @(posedge clk); #1;
        bus.ReadReq = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int nwords);
        for (int i = 0; i < 200 && !done_seen; i++) @(posedge clk);
        #1;
        check({tag, "_done_seen"}, 64'(done_seen), 64'd1);
        check({tag, "_words"}, 64'(words), 64'(nwords));
        check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        check({tag, "_busy_low"}, 64'(bus.Busy), 64'd0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !bus.DataValid; i++) begin
            @(posedge clk); #1;
        end
        check("valid_seen", 64'(bus.DataValid), 64'd1);
    endtask

    initial begin
        logic [DATA_W-1:0] held;
        bus.ReadReq = 1'b0;
        bus.HitIn = '0;
        bus.TotIn = '0;
        bus.DataReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 64'(bus.DataValid), 64'd0);
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        check("rst_dataout", 64'(bus.DataOut), 64'd0);
        check("rst_wordcnt", 64'(bus.WordCnt), 64'd0);

        // empty frame
        start_frame(16'h0000);
        check("empty_busy", 64'(bus.Busy), 64'd1);
        wait_done("empty", 0);
        check("empty_done_latency", 64'(done_cyc - req_cyc), 64'd2);

        // sparse frame
        tput_chk = 1;
        start_frame(16'h8011);
        wait_done("sparse", 3);

        // full frame
        start_frame(16'hFFFF);
        wait_done("full", 16);
        tput_chk = 0;

        // backpressure on the first word
        bus.DataReady = 1'b0;
        start_frame(16'h0006);
        wait_valid();
        held = {ADDR_W'(1), bus.TotIn[1*ROW_W +: ROW_W]};
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_hold_data", 64'(bus.DataOut), 64'(held));
            check("bp_hold_valid", 64'(bus.DataValid), 64'd1);
        end
        bus.DataReady = 1'b1;
        wait_done("backpressure", 2);

        // snapshot: new hit and ReadReq in SEND and DONE are ignored
        start_frame(16'h0001);
        bus.HitIn = 16'h0009;
        @(posedge clk); #1;
        bus.ReadReq = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.ReadReq = 1'b0;
        check("snap_busy_after", 64'(bus.Busy), 64'd0);
        check("snap_done_seen", 64'(done_seen), 64'd1);
        check("snap_words", 64'(words), 64'd1);
        @(posedge clk); #1;
        check("snap_stay_idle", 64'(bus.Busy), 64'd0);
        start_frame(16'h0008);
        wait_done("snap_next", 1);

        // reset while sending address 4
        bus.DataReady = 1'b0;
        start_frame(16'h00F0);
        wait_valid();
        check("rst_mid_addr", 64'(bus.DataOut[ROW_W +: ADDR_W]), 64'd4);
        exp_q.delete();
        cnt_q.delete();
        bus.DataReady = 1'b1;
        rst = 1'b1;
        done_seen = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid", 64'(bus.DataValid), 64'd0);
        check("mid_rst_busy", 64'(bus.Busy), 64'd0);
        check("mid_rst_done", 64'(bus.Done), 64'd0);
        check("mid_rst_clear", 64'(bus.ClearRow), 64'd0);
        check("mid_rst_dataout", 64'(bus.DataOut), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_no_done", 64'(done_seen), 64'd0);
        tput_chk = 1;
        start_frame(16'h00F0);
        wait_done("reread", 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
